// File: rtl/mem_pkg.sv
// Shared store-path definitions: size codes, FSM states, alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Overlays byte/halfword/word store data onto an existing memory word.
// Little-endian lanes; upper store bits beyond the access width are dropped.
module store_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    unique case (size)
      SZ_BYTE: merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged_word = wdata;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data RAM; sub-word stores use read-modify-write.
// busy feeds the hazard unit to hold the pipeline while a store is in flight.
module store_rmw_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign_err
);

  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] merged;

  store_lane_merge u_merge (
    .old_word    (mem_rdata),
    .wdata       (wdata_q),
    .size        (size_q),
    .lane        (lane_q),
    .merged_word (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wdata_q  <= '0;
      merge_q  <= '0;
      size_q   <= SZ_BYTE;
      lane_q   <= 2'b00;
      mem_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wdata_q <= req_wdata;
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state <= ST_ERR;
            end else begin
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              // word stores write straight through; sub-word ones get overwritten in MERGE
              merge_q  <= req_wdata;
              state    <= (req_size == SZ_WORD) ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ:  state <= ST_MERGE;
        ST_MERGE: begin
          merge_q <= merged;
          state   <= ST_WRITE;
        end
        ST_WRITE: state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign mem_re       = (state == ST_READ);
  assign mem_we       = (state == ST_WRITE);
  assign done         = (state == ST_WRITE);
  assign misalign_err = (state == ST_ERR);
  assign mem_wdata    = merge_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed vectors, corner sequences, random vs model.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [31:0] model_mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          we_count = 0;

  always #5 clk = ~clk;

  store_rmw_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .misalign_err (misalign_err)
  );

  // Synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
    if (mem_we) we_count <= we_count + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx[3:0]; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
    model_mem[idx] = val;
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a[0]) return 1'b1;
    if (s == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] s);
    int sh;
    logic [31:0] m;
    if (s == 2'd2) return d;
    if (s == 2'd0) begin
      sh = 8 * a[1:0];
      m = 32'hFF << sh;
    end else begin
      sh = 16 * a[1];
      m = 32'hFFFF << sh;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Issue one store from IDLE and observe the following five cycles.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          output int lat, output logic [31:0] wd, output logic [31:0] wa,
                          output logic err, output int nre, output int nwe,
                          output int ndone, output logic rdy2);
    int n;
    lat = -1; wd = '0; wa = '0; err = 1'b0; nre = 0; nwe = 0; ndone = 0; rdy2 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_size = s;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int c = 1; c <= 5; c++) begin
      if (mem_re) nre++;
      if (done) ndone++;
      if (done && !mem_we) ndone += 100;
      if (mem_we) begin
        nwe++;
        if (lat < 0) begin lat = c; wd = mem_wdata; wa = mem_addr; end
      end
      if (misalign_err) begin err = 1'b1; lat = c; end
      if (c == 2) rdy2 = req_ready;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] init;
    logic        err;
    logic [31:0] exp_wd;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, nre, nwe, ndone, idx, c_done, c_acc, wc0;
    logic [31:0] wd, wa, a, d, e;
    logic err, rdy2;
    logic [1:0] s;

    vecs[0] = '{32'h10, 32'hDEADBEEF, 2'b10, 32'h55555555, 1'b0, 32'hDEADBEEF, 1};
    vecs[1] = '{32'h13, 32'hFFFFFFA5, 2'b00, 32'h11223344, 1'b0, 32'hA5223344, 3};
    vecs[2] = '{32'h22, 32'h0000BEEF, 2'b01, 32'h11223344, 1'b0, 32'hBEEF3344, 3};
    vecs[3] = '{32'h20, 32'h00000077, 2'b00, 32'h11223344, 1'b0, 32'h11223377, 3};
    vecs[4] = '{32'h21, 32'h123456AB, 2'b00, 32'h11223344, 1'b0, 32'h1122AB44, 3};
    vecs[5] = '{32'h20, 32'h12345678, 2'b01, 32'h11223344, 1'b0, 32'h11225678, 3};
    vecs[6] = '{32'h21, 32'h0000BEEF, 2'b01, 32'h11223344, 1'b1, 32'h0, 1};
    vecs[7] = '{32'h22, 32'hCAFEF00D, 2'b10, 32'h11223344, 1'b1, 32'h0, 1};
    vecs[8] = '{32'h10, 32'hCAFEF00D, 2'b11, 32'h11223344, 1'b1, 32'h0, 1};
    vecs[9] = '{32'h13, 32'hCAFEF00D, 2'b10, 32'h11223344, 1'b1, 32'h0, 1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) preload(i, $urandom);

    foreach (vecs[i]) begin
      idx = int'(vecs[i].addr[5:2]);
      preload(idx, vecs[i].init);
      do_store(vecs[i].addr, vecs[i].wdata, vecs[i].size, lat, wd, wa, err, nre, nwe, ndone, rdy2);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_nwe", i), nwe, 0);
        chk($sformatf("v%0d_nre", i), nre, 0);
        chk($sformatf("v%0d_done", i), ndone, 0);
        chk($sformatf("v%0d_ready2", i), {31'd0, rdy2}, 32'd1);
        chk($sformatf("v%0d_mem", i), mem[idx], vecs[i].init);
      end else begin
        chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
        chk($sformatf("v%0d_addr", i), wa, vecs[i].addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d_nre", i), nre, (vecs[i].size == 2'b10) ? 0 : 1);
        chk($sformatf("v%0d_nwe", i), nwe, 1);
        chk($sformatf("v%0d_done", i), ndone, 1);
        model_mem[idx] = vecs[i].exp_wd;
      end
    end

    // Reset while a byte store sits in MERGE
    preload(5, 32'h01020304);
    @(negedge clk);
    wc0 = we_count;
    req_valid = 1'b1; req_addr = 32'h15; req_wdata = 32'hEE; req_size = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_write", we_count, wc0);
    chk("midrst_mem", mem[5], 32'h01020304);
    do_store(32'h15, 32'hEE, 2'b00, lat, wd, wa, err, nre, nwe, ndone, rdy2);
    chk("post_rst_wdata", wd, 32'h0102EE04);
    chk("post_rst_lat", lat, 3);
    model_mem[5] = 32'h0102EE04;

    // Back-to-back byte stores into the same word with req_valid held
    preload(12, 32'hA0B0C0D0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h30; req_wdata = 32'h11; req_size = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h31; req_wdata = 32'h22;
    c_done = -1; c_acc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (done && c_done < 0) c_done = c;
      if (c <= 3) chk($sformatf("b2b_ready_low_c%0d", c), {31'd0, req_ready}, 32'd0);
      if (req_ready && c_acc < 0) begin
        c_acc = c;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        c++;
      end else begin
        @(negedge clk);
      end
    end
    chk("b2b_done_cycle", c_done, 3);
    chk("b2b_accept_cycle", c_acc, 4);
    chk("b2b_mem", mem[12], 32'hA0B02211);
    model_mem[12] = 32'hA0B02211;

    // Random stores checked against the byte-lane model
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(63, 0);
      d = $urandom;
      s = 2'($urandom_range(3, 0));
      idx = int'(a[5:2]);
      do_store(a, d, s, lat, wd, wa, err, nre, nwe, ndone, rdy2);
      chk($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, model_err(a, s)});
      if (!model_err(a, s)) begin
        model_mem[idx] = model_store(model_mem[idx], a, d, s);
        chk($sformatf("rnd%0d_lat", i), lat, (s == 2'b10) ? 1 : 3);
      end else begin
        chk($sformatf("rnd%0d_nwe", i), nwe, 0);
      end
      e = model_mem[idx];
      chk($sformatf("rnd%0d_mem", i), mem[idx], e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
